wqe_dispatch_arbiter: RTL and testbench
=======================================

WQE_DISPATCH_ARBITER -- requirements
Module: wqe_dispatch_arbiter

Interface
REQ-001 Parameter SQ_WEIGHT, default 2, meaning: consecutive SQ grants allowed while RQ also pending (legal range 1-15).
REQ-002 Parameter DONE_TIMEOUT, default 255, meaning: max cycles in WAIT_DONE before timeout (legal range 1-65535).
REQ-003 clock  input  1  single core clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = arbitration allowed; 0 = no new grants, in-flight descriptor completes.
REQ-006 sqEmpty  input  1  SQ FIFO empty flag.
REQ-007 sqData  input  112  SQ FIFO head entry, show-ahead (valid whenever sqEmpty=0).
REQ-008 sqPop  output  1  one-cycle SQ FIFO pop strobe.
REQ-009 rqEmpty  input  1  RQ FIFO empty flag.
REQ-010 rqData  input  112  RQ FIFO head entry, show-ahead.
REQ-011 rqPop  output  1  one-cycle RQ FIFO pop strobe.
REQ-012 dmaValid  output  1  descriptor offered to DMA engine.
REQ-013 dmaReady  input  1  DMA engine accepts descriptor.
REQ-014 dmaDesc  output  112  latched descriptor, stable while dmaValid=1.
REQ-015 dmaQueue  output  1  source of dmaDesc: 0=SQ, 1=RQ.
REQ-016 dmaDone  input  1  one-cycle completion pulse from DMA engine.
REQ-017 busy  output  1  1 whenever state != IDLE.
REQ-018 sqIssued  output  16  count of SQ descriptors accepted by DMA.
REQ-019 rqIssued  output  16  count of RQ descriptors accepted by DMA.
REQ-020 dropCount  output  8  count of descriptors discarded (dataNum==0).
REQ-021 timeoutErr  output  1  sticky: a WAIT_DONE timeout occurred.

Function
REQ-022 States SHALL be IDLE, POP, ISSUE, WAIT_DONE; one descriptor in flight at a time.
REQ-023 IDLE: if enable=1 and at least one FIFO non-empty, select a queue per REQ-024/025 and go to POP; otherwise stay.
REQ-024 Only one FIFO non-empty: that FIFO is selected regardless of credit.
REQ-025 Both non-empty: SQ selected while sqCredit < SQ_WEIGHT, else RQ; each SQ grant increments sqCredit; an RQ grant, or SQ grant while rqEmpty=1, clears sqCredit to 0.
REQ-026 POP: assert selected pop for exactly one cycle, latch head data into dmaDesc and queue id into dmaQueue in that same cycle; next state ISSUE.
REQ-027 ISSUE: if dmaDesc[106:104] (dataNum)==0, drop: no dmaValid, dropCount increments (saturating at 255), return IDLE.
REQ-028 ISSUE otherwise: dmaValid=1 and held with dmaDesc/dmaQueue stable until dmaReady=1; on the accepting cycle increment sqIssued or rqIssued (wrap at 16 bits), go to WAIT_DONE.
REQ-029 WAIT_DONE: 16-bit timer cleared on entry, increments per cycle; dmaDone=1 returns to IDLE; timer reaching DONE_TIMEOUT sets timeoutErr and returns to IDLE.
REQ-030 dmaDone outside WAIT_DONE SHALL be ignored.
REQ-031 dmaDone and timer expiry in the same cycle: treat as done; timeoutErr not set.
REQ-032 enable deasserted in POP/ISSUE/WAIT_DONE: current descriptor completes normally; no new grant taken from IDLE.
REQ-033 Minimum grant-to-grant spacing: 4 cycles (IDLE, POP, ISSUE, WAIT_DONE with dmaReady and dmaDone each 1 cycle).
REQ-034 sqPop and rqPop SHALL never assert in the same cycle and never assert on an empty FIFO.

Reset
REQ-035 reset=0 asynchronously forces IDLE; sqPop, rqPop, dmaValid, busy, dmaQueue, timeoutErr = 0; dmaDesc = 0; sqIssued, rqIssued, dropCount, sqCredit, timer = 0.
REQ-036 Reset mid-ISSUE or mid-WAIT_DONE abandons the descriptor; no pop, count or error after release; first grant no earlier than the 2nd clock edge after reset release.

Verification
REQ-037 SQ holds 3 entries (dataNum=1), RQ empty, dmaReady=1, dmaDone 1 cycle after accept -> 3 sqPop pulses 4 cycles apart, sqIssued=3, dmaQueue=0 throughout.
REQ-038 Both FIFOs hold 6 entries, SQ_WEIGHT=2 -> grant order S,S,R,S,S,R,...; after SQ drains, remaining RQ entries back-to-back.
REQ-039 dmaReady held 0 for 10 cycles in ISSUE -> dmaValid and dmaDesc stable for all 10 cycles; single rqIssued increment on acceptance.
REQ-040 Entry with dataNum=0 at SQ head -> one sqPop, no dmaValid, dropCount=1, next entry issued normally.
REQ-041 DONE_TIMEOUT=8, dmaDone never asserted -> timeoutErr=1 after 8 cycles in WAIT_DONE, state IDLE, next entry granted; second case dmaDone coincident with expiry -> timeoutErr stays 0.
REQ-042 reset pulled low in WAIT_DONE with counters non-zero -> all outputs per REQ-035 immediately, no pop in cycle after release.

Source files
------------

// File: rtl/wqe_dispatch_arbiter.sv
// Weighted SQ/RQ work-queue-entry arbiter: pops one descriptor at a time from the
// show-ahead FIFOs, offers it to the DMA engine and waits for completion or timeout.
`timescale 1ns/1ps
module wqe_dispatch_arbiter #(
    parameter int SQ_WEIGHT    = 2,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         sqEmpty,
    input  logic [111:0] sqData,
    output logic         sqPop,
    input  logic         rqEmpty,
    input  logic [111:0] rqData,
    output logic         rqPop,
    output logic         dmaValid,
    input  logic         dmaReady,
    output logic [111:0] dmaDesc,
    output logic         dmaQueue,
    input  logic         dmaDone,
    output logic         busy,
    output logic [15:0]  sqIssued,
    output logic [15:0]  rqIssued,
    output logic [7:0]   dropCount,
    output logic         timeoutErr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        POP       = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } arbState;

    localparam logic [3:0]  CREDIT_LIMIT = 4'(SQ_WEIGHT);
    localparam logic [15:0] TIMER_LAST   = 16'(DONE_TIMEOUT - 1);

    arbState        stateReg;
    arbState        stateNext;
    logic           armedReg;
    logic           selQueueReg;
    logic [3:0]     sqCreditReg;
    logic [15:0]    timerReg;
    logic [111:0]   dmaDescReg;
    logic           dmaQueueReg;
    logic [15:0]    sqIssuedReg;
    logic [15:0]    rqIssuedReg;
    logic [7:0]     dropCountReg;
    logic           timeoutErrReg;

    logic canGrant;
    logic grantSq;
    logic selEmpty;
    logic dataNumZero;
    logic accept;
    logic timerExpired;

    // armedReg holds off the first grant until the second edge after reset release
    assign canGrant     = armedReg && enable && (!sqEmpty || !rqEmpty);
    assign grantSq      = !sqEmpty && (rqEmpty || (sqCreditReg < CREDIT_LIMIT));
    assign selEmpty     = selQueueReg ? rqEmpty : sqEmpty;
    assign dataNumZero  = (dmaDescReg[106:104] == 3'd0);
    assign accept       = (stateReg == ISSUE) && !dataNumZero && dmaReady;
    assign timerExpired = (timerReg == TIMER_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:      if (canGrant) stateNext = POP;
            POP:       stateNext = selEmpty ? IDLE : ISSUE;
            ISSUE: begin
                if (dataNumZero) stateNext = IDLE;
                else if (dmaReady) stateNext = WAIT_DONE;
            end
            WAIT_DONE: if (dmaDone || timerExpired) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_comb begin
        sqPop    = (stateReg == POP) && !selQueueReg && !sqEmpty;
        rqPop    = (stateReg == POP) &&  selQueueReg && !rqEmpty;
        dmaValid = (stateReg == ISSUE) && !dataNumZero;
        busy     = (stateReg != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armedReg      <= 1'b0;
            selQueueReg   <= 1'b0;
            sqCreditReg   <= 4'd0;
            timerReg      <= 16'd0;
            dmaDescReg    <= '0;
            dmaQueueReg   <= 1'b0;
            sqIssuedReg   <= 16'd0;
            rqIssuedReg   <= 16'd0;
            dropCountReg  <= 8'd0;
            timeoutErrReg <= 1'b0;
        end else begin
            armedReg <= 1'b1;

            // Credit only accumulates while RQ is actually competing for the slot
            if (stateReg == IDLE && canGrant) begin
                selQueueReg <= !grantSq;
                if (grantSq && !rqEmpty) sqCreditReg <= sqCreditReg + 4'd1;
                else                     sqCreditReg <= 4'd0;
            end

            if (sqPop || rqPop) begin
                dmaDescReg  <= selQueueReg ? rqData : sqData;
                dmaQueueReg <= selQueueReg;
            end

            if (stateReg == ISSUE && dataNumZero && dropCountReg != 8'hFF) begin
                dropCountReg <= dropCountReg + 8'd1;
            end

            if (accept) begin
                if (dmaQueueReg) rqIssuedReg <= rqIssuedReg + 16'd1;
                else             sqIssuedReg <= sqIssuedReg + 16'd1;
            end

            if (stateReg == WAIT_DONE) timerReg <= timerReg + 16'd1;
            else                       timerReg <= 16'd0;

            // A completion in the expiry cycle wins over the timeout
            if (stateReg == WAIT_DONE && timerExpired && !dmaDone) begin
                timeoutErrReg <= 1'b1;
            end
        end
    end

    assign dmaDesc    = dmaDescReg;
    assign dmaQueue   = dmaQueueReg;
    assign sqIssued   = sqIssuedReg;
    assign rqIssued   = rqIssuedReg;
    assign dropCount  = dropCountReg;
    assign timeoutErr = timeoutErrReg;

endmodule

// File: tb/tb_wqe_dispatch_arbiter.sv
// Directed bench for wqe_dispatch_arbiter: show-ahead FIFO models, a scripted DMA
// responder, grant/accept logs and hand-computed expectations.
`timescale 1ns/1ps
module tb_wqe_dispatch_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         sqEmpty = 1'b1;
    logic [111:0] sqData = '0;
    logic         sqPop;
    logic         rqEmpty = 1'b1;
    logic [111:0] rqData = '0;
    logic         rqPop;
    logic         dmaValid;
    logic         dmaReady;
    logic [111:0] dmaDesc;
    logic         dmaQueue;
    logic         dmaDone = 1'b0;
    logic         busy;
    logic [15:0]  sqIssued;
    logic [15:0]  rqIssued;
    logic [7:0]   dropCount;
    logic         timeoutErr;

    int testCount = 0;
    int failCount = 0;

    wqe_dispatch_arbiter #(.SQ_WEIGHT(2), .DONE_TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .sqEmpty(sqEmpty), .sqData(sqData), .sqPop(sqPop),
        .rqEmpty(rqEmpty), .rqData(rqData), .rqPop(rqPop),
        .dmaValid(dmaValid), .dmaReady(dmaReady), .dmaDesc(dmaDesc),
        .dmaQueue(dmaQueue), .dmaDone(dmaDone), .busy(busy),
        .sqIssued(sqIssued), .rqIssued(rqIssued), .dropCount(dropCount),
        .timeoutErr(timeoutErr)
    );

    always #5 clock = ~clock;

    // FIFO storage: written only by the stimulus, read pointers owned by the model
    logic [111:0] sqMem [0:63];
    logic [111:0] rqMem [0:63];
    logic [5:0]   sqWr = 6'd0, sqRd = 6'd0, rqWr = 6'd0, rqRd = 6'd0;
    logic         sqTake, rqTake;
    assign sqTake = sqPop && (sqRd != sqWr);
    assign rqTake = rqPop && (rqRd != rqWr);

    logic [7:0]   grantQ    [0:63];
    int           grantCyc  [0:63];
    logic [5:0]   grantCnt = 6'd0;
    logic [111:0] acceptDesc [0:63];
    logic [5:0]   acceptCnt = 6'd0;
    int           cyc = 0;
    int           popBothErr = 0;
    int           popEmptyErr = 0;
    int           validZeroErr = 0;
    int           rqValidCycles = 0;
    int           doneDelay = 1;
    int           doneCnt = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (sqPop && rqPop) popBothErr <= popBothErr + 1;
        if ((sqPop && !sqTake) || (rqPop && !rqTake)) popEmptyErr <= popEmptyErr + 1;
        if (sqPop || rqPop) begin
            grantQ[grantCnt]   <= sqPop ? 8'h53 : 8'h52;
            grantCyc[grantCnt] <= cyc;
            grantCnt           <= grantCnt + 6'd1;
        end
        sqRd    <= sqRd + {5'd0, sqTake};
        rqRd    <= rqRd + {5'd0, rqTake};
        sqEmpty <= ((sqRd + {5'd0, sqTake}) == sqWr);
        rqEmpty <= ((rqRd + {5'd0, rqTake}) == rqWr);
        sqData  <= sqMem[sqRd + {5'd0, sqTake}];
        rqData  <= rqMem[rqRd + {5'd0, rqTake}];
        if (dmaValid && dmaReady) begin
            acceptDesc[acceptCnt] <= dmaDesc;
            acceptCnt             <= acceptCnt + 6'd1;
        end
        if (dmaValid && dmaDesc[106:104] == 3'd0) validZeroErr <= validZeroErr + 1;
        if (dmaValid && dmaQueue) rqValidCycles <= rqValidCycles + 1;
    end

    // DMA responder: completion pulse doneDelay cycles after acceptance (0 = never)
    always @(posedge clock) begin
        dmaDone <= 1'b0;
        if (doneCnt != 0) begin
            doneCnt <= doneCnt - 1;
            if (doneCnt == 1) dmaDone <= 1'b1;
        end
        if (dmaValid && dmaReady && doneDelay != 0) begin
            if (doneDelay == 1) dmaDone <= 1'b1;
            else                doneCnt <= doneDelay - 1;
        end
    end

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [111:0] mkEntry(input logic [31:0] tag, input logic [2:0] dataNum);
        logic [111:0] e;
        e = '0;
        e[31:0]    = tag;
        e[106:104] = dataNum;
        return e;
    endfunction

    task automatic pushSq(input logic [111:0] e);
        sqMem[sqWr] = e;
        sqWr = sqWr + 6'd1;
    endtask

    task automatic pushRq(input logic [111:0] e);
        rqMem[rqWr] = e;
        rqWr = rqWr + 6'd1;
    endtask

    task automatic waitAccept(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (dmaValid && dmaReady) begin
                ok = 1'b1;
                break;
            end
        end
        checkVal(tag, {127'd0, ok}, 128'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_busy"},       {127'd0, busy},       128'd0);
        checkVal({tag, "_dmaValid"},   {127'd0, dmaValid},   128'd0);
        checkVal({tag, "_sqPop"},      {127'd0, sqPop},      128'd0);
        checkVal({tag, "_rqPop"},      {127'd0, rqPop},      128'd0);
        checkVal({tag, "_sqIssued"},   {112'd0, sqIssued},   128'd0);
        checkVal({tag, "_rqIssued"},   {112'd0, rqIssued},   128'd0);
        checkVal({tag, "_dropCount"},  {120'd0, dropCount},  128'd0);
        checkVal({tag, "_timeoutErr"}, {127'd0, timeoutErr}, 128'd0);
        checkVal({tag, "_dmaDesc"},    {16'd0, dmaDesc},     128'd0);
        checkVal({tag, "_dmaQueue"},   {127'd0, dmaQueue},   128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]   g0;
        logic [5:0]   a0;
        int           rv0;
        int           bad;
        bit           found;
        string        order;
        logic [111:0] e;

        reset = 1'b0; enable = 1'b0; dmaReady = 1'b1; doneDelay = 1;
        repeat (3) @(negedge clock);
        checkResetOutputs("reset");
        reset = 1'b1; enable = 1'b1;

        // Three SQ entries, RQ idle: pops 4 cycles apart
        g0 = grantCnt; a0 = acceptCnt; rv0 = rqValidCycles;
        for (int i = 0; i < 3; i++) pushSq(mkEntry(32'h100 + i, 3'd1));
        repeat (20) @(negedge clock);
        $display("[TB] t1 three SQ entries: grants=%0d sqIssued=%0d", grantCnt - g0, sqIssued);
        checkVal("t1_grants", {122'd0, grantCnt - g0}, 128'd3);
        for (int i = 0; i < 3; i++) checkVal("t1_src", {120'd0, grantQ[g0 + 6'(i)]}, 128'h53);
        for (int i = 1; i < 3; i++)
            checkVal("t1_spacing", 128'(grantCyc[g0 + 6'(i)] - grantCyc[g0 + 6'(i - 1)]), 128'd4);
        checkVal("t1_desc", {16'd0, acceptDesc[a0 + 6'd2]}, {16'd0, mkEntry(32'h102, 3'd1)});
        checkVal("t1_sqIssued", {112'd0, sqIssued}, 128'd3);
        checkVal("t1_queue", 128'(rqValidCycles - rv0), 128'd0);

        // Both FIFOs loaded: weighted order, then RQ drains alone
        g0 = grantCnt;
        for (int i = 0; i < 6; i++) pushSq(mkEntry(32'h200 + i, 3'd1));
        for (int i = 0; i < 6; i++) pushRq(mkEntry(32'h300 + i, 3'd1));
        repeat (70) @(negedge clock);
        $display("[TB] t2 weighted arbitration: grants=%0d sqIssued=%0d rqIssued=%0d",
                 grantCnt - g0, sqIssued, rqIssued);
        order = "SSRSSRSSRRRR";
        checkVal("t2_grants", {122'd0, grantCnt - g0}, 128'd12);
        for (int i = 0; i < 12; i++)
            checkVal("t2_order", {120'd0, grantQ[g0 + 6'(i)]}, {120'd0, order[i]});
        checkVal("t2_rq_spacing", 128'(grantCyc[g0 + 6'd11] - grantCyc[g0 + 6'd10]), 128'd4);
        checkVal("t2_sqIssued", {112'd0, sqIssued}, 128'd9);
        checkVal("t2_rqIssued", {112'd0, rqIssued}, 128'd6);

        // DMA back-pressure: descriptor held for 10 cycles
        dmaReady = 1'b0;
        e = mkEntry(32'h400, 3'd3);
        pushRq(e);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (dmaValid) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("t3_valid_seen", {127'd0, found}, 128'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!dmaValid || dmaDesc !== e || dmaQueue !== 1'b1) bad++;
            @(negedge clock);
        end
        $display("[TB] t3 stall 10 cycles: unstable=%0d rqIssued=%0d", bad, rqIssued);
        checkVal("t3_stable", 128'(bad), 128'd0);
        checkVal("t3_no_early_count", {112'd0, rqIssued}, 128'd6);
        dmaReady = 1'b1;
        repeat (5) @(negedge clock);
        checkVal("t3_rqIssued", {112'd0, rqIssued}, 128'd7);
        checkVal("t3_desc", {16'd0, acceptDesc[acceptCnt - 6'd1]}, {16'd0, e});

        // Zero-length entry dropped, next one issued
        g0 = grantCnt; a0 = acceptCnt;
        pushSq(mkEntry(32'h500, 3'd0));
        pushSq(mkEntry(32'h501, 3'd2));
        repeat (20) @(negedge clock);
        $display("[TB] t4 drop: grants=%0d accepts=%0d dropCount=%0d", grantCnt - g0, acceptCnt - a0, dropCount);
        checkVal("t4_grants", {122'd0, grantCnt - g0}, 128'd2);
        checkVal("t4_dropCount", {120'd0, dropCount}, 128'd1);
        checkVal("t4_accepts", {122'd0, acceptCnt - a0}, 128'd1);
        checkVal("t4_desc", {16'd0, acceptDesc[a0]}, {16'd0, mkEntry(32'h501, 3'd2)});
        checkVal("t4_no_zero_valid", 128'(validZeroErr), 128'd0);
        checkVal("t4_sqIssued", {112'd0, sqIssued}, 128'd10);

        // Timeout after 8 WAIT_DONE cycles, following entry still served
        g0 = grantCnt;
        doneDelay = 0;
        pushSq(mkEntry(32'h600, 3'd1));
        pushSq(mkEntry(32'h601, 3'd1));
        waitAccept("t5_accept");
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (timeoutErr || !busy) bad++;
        end
        @(negedge clock);
        doneDelay = 1;
        $display("[TB] t5 timeout: early=%0d timeoutErr=%0d busy=%0d", bad, timeoutErr, busy);
        checkVal("t5_wait_8", 128'(bad), 128'd0);
        checkVal("t5_timeoutErr", {127'd0, timeoutErr}, 128'd1);
        checkVal("t5_idle", {127'd0, busy}, 128'd0);
        repeat (15) @(negedge clock);
        checkVal("t5_next_grant", {122'd0, grantCnt - g0}, 128'd2);
        checkVal("t5_sqIssued", {112'd0, sqIssued}, 128'd12);

        // Reset in WAIT_DONE abandons the descriptor
        doneDelay = 0;
        pushSq(mkEntry(32'h700, 3'd1));
        waitAccept("t6_accept");
        repeat (2) @(negedge clock);
        checkVal("t6_busy_before", {127'd0, busy}, 128'd1);
        checkVal("t6_count_before", {112'd0, sqIssued}, 128'd13);
        reset = 1'b0;
        #1;
        $display("[TB] t6 reset in WAIT_DONE: busy=%0d sqIssued=%0d timeoutErr=%0d", busy, sqIssued, timeoutErr);
        checkResetOutputs("t6_async");
        doneDelay = 1;
        pushSq(mkEntry(32'h701, 3'd1));
        @(negedge clock);
        g0 = grantCnt;
        reset = 1'b1;
        @(negedge clock);
        checkVal("t6_no_early_pop", {127'd0, sqPop}, 128'd0);
        repeat (12) @(negedge clock);
        checkVal("t6_timeoutErr", {127'd0, timeoutErr}, 128'd0);
        checkVal("t6_grants", {122'd0, grantCnt - g0}, 128'd1);
        checkVal("t6_sqIssued", {112'd0, sqIssued}, 128'd1);
        checkVal("t6_desc", {16'd0, acceptDesc[acceptCnt - 6'd1]}, {16'd0, mkEntry(32'h701, 3'd1)});

        // Completion coincident with expiry counts as done
        doneDelay = 8;
        pushSq(mkEntry(32'h800, 3'd1));
        waitAccept("t7_accept");
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (timeoutErr || !busy) bad++;
        end
        @(negedge clock);
        $display("[TB] t7 done at expiry: early=%0d timeoutErr=%0d busy=%0d", bad, timeoutErr, busy);
        checkVal("t7_wait_8", 128'(bad), 128'd0);
        checkVal("t7_timeoutErr", {127'd0, timeoutErr}, 128'd0);
        checkVal("t7_idle", {127'd0, busy}, 128'd0);
        checkVal("t7_sqIssued", {112'd0, sqIssued}, 128'd2);

        checkVal("pop_both", 128'(popBothErr), 128'd0);
        checkVal("pop_empty", 128'(popEmptyErr), 128'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
